// File: rtl/data_break.sv
// data_break: memory-side responder for the disk DMA (data-break) handshake.
//
// Takes one word-transfer request at a time from the disk engine, waits for
// the CPU to offer a break slot, performs exactly one memory read or write
// on the disk's behalf and answers with a one-cycle grant.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   clear           synchronous IOCLR (aborts only a transfer that has not
//                   yet touched memory)
//   dmaREQ/RD/WR    request and direction from the disk engine
//   dmaADDR/DOUT    word address and write data, stable while dmaREQ
//   dmaGNT          one-cycle transfer-complete pulse
//   dmaDIN          read data, valid in the grant cycle and held until the
//                   next read completes
//   brk_ok          CPU may accept a break cycle now
//   brk_hold        CPU must keep off memory while high
//   mem_*           single-port memory interface; mem_rdata arrives
//                   READ_LATENCY cycles after mem_re
//   proto_err       one-cycle pulse when a request has RD == WR
//
// Every output is driven straight from a flop.
module data_break #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              dmaREQ,
    input  logic              dmaRD,
    input  logic              dmaWR,
    input  logic [ADDR_W-1:0] dmaADDR,
    input  logic [11:0]       dmaDOUT,
    output logic              dmaGNT,
    output logic [11:0]       dmaDIN,
    input  logic              brk_ok,
    output logic              brk_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [11:0]       mem_rdata,
    output logic              proto_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_SLOT = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ_WAIT = 3'd3;
    localparam logic [2:0] S_GRANT     = 3'd4;

    // READ_WAIT starts with the counter at 0 in the mem_re cycle, so the
    // read data is due in the cycle where the counter equals the latency.
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    logic [2:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic [11:0]       din_q, din_d;
    logic              gnt_q, gnt_d;
    logic              hold_q, hold_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              err_q, err_d;

    // Set when the memory slot has been obtained this cycle; the direction
    // comes from the live request in IDLE or the latched one in WAIT_SLOT.
    logic launch;
    logic launch_wr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        din_d     = din_q;
        gnt_d     = 1'b0;
        hold_d    = 1'b0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        err_d     = 1'b0;
        launch    = 1'b0;
        launch_wr = is_wr_q;

        case (state_q)
            S_IDLE: begin
                if (!clear && dmaREQ) begin
                    if (dmaRD == dmaWR) begin
                        // Ambiguous direction: complete the handshake with
                        // an error flag but never touch memory.
                        state_d = S_GRANT;
                        gnt_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        addr_d    = dmaADDR;
                        wdata_d   = dmaDOUT;
                        is_wr_d   = dmaWR;
                        launch_wr = dmaWR;
                        if (brk_ok) begin
                            launch = 1'b1;
                        end else begin
                            state_d = S_WAIT_SLOT;
                        end
                    end
                end
            end
            S_WAIT_SLOT: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (brk_ok) begin
                    launch = 1'b1;
                end
            end
            S_WRITE: begin
                hold_d  = 1'b1;
                gnt_d   = 1'b1;
                state_d = S_GRANT;
            end
            S_READ_WAIT: begin
                hold_d = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    din_d   = mem_rdata;
                    gnt_d   = 1'b1;
                    state_d = S_GRANT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_GRANT: begin
                // dmaREQ is deliberately not looked at here: the requester
                // only sees the grant during this cycle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Once the slot is taken the transfer cannot be torn: clear and
        // brk_ok are no longer examined until the grant has gone out.
        if (launch) begin
            hold_d = 1'b1;
            cnt_d  = '0;
            if (launch_wr) begin
                state_d = S_WRITE;
                we_d    = 1'b1;
            end else begin
                state_d = S_READ_WAIT;
                re_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            gnt_q   <= 1'b0;
            hold_q  <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            re_q    <= re_d;
            err_q   <= err_d;
        end
    end

    assign dmaGNT    = gnt_q;
    assign dmaDIN    = din_q;
    assign brk_hold  = hold_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_data_break.sv
// tb_data_break: self-checking bench for data_break.
//
// Two lanes run side by side, one DUT with READ_LATENCY=1 and one with
// READ_LATENCY=3, each with its own memory model.  Every transfer is
// described by a few numbers (direction, legality, wait length, clear
// timing) and the expected per-cycle outputs are derived from those numbers
// directly: grant cycle, hold window, strobe cycle and read data.
module tb_data_break;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Power-up contents of every memory word not yet written.
    function automatic logic [11:0] init_val(input int a);
        return 12'((a * 29 + 12'o1357) & 32'hfff);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : lane
        localparam int RL = (gi == 0) ? 1 : 3;

        logic        reset, clear, req, rd, wr, brk_ok;
        logic        gnt, hold, we, re, err;
        logic [14:0] addr, maddr;
        logic [11:0] dout, din, wdata, rdata;
        logic [11:0] mem [32768];
        bit          wr_seen [32768];
        logic [11:0] rpipe [RL];
        logic [11:0] ref_mem [int];
        logic [11:0] last_din;
        logic [14:0] pool [8];
        bit          done = 1'b0;

        data_break #(.READ_LATENCY(RL), .ADDR_W(15)) dut (
            .clk(clk), .reset(reset), .clear(clear),
            .dmaREQ(req), .dmaRD(rd), .dmaWR(wr),
            .dmaADDR(addr), .dmaDOUT(dout),
            .dmaGNT(gnt), .dmaDIN(din),
            .brk_ok(brk_ok), .brk_hold(hold),
            .mem_addr(maddr), .mem_wdata(wdata),
            .mem_we(we), .mem_re(re), .mem_rdata(rdata),
            .proto_err(err)
        );

        // Memory: data is valid exactly RL cycles after mem_re, junk otherwise.
        always @(posedge clk) begin
            if (we) begin
                mem[maddr]     <= wdata;
                wr_seen[maddr] <= 1'b1;
            end
            if (re) rpipe[0] <= wr_seen[maddr] ? mem[maddr] : init_val(int'(maddr));
            else    rpipe[0] <= 12'($urandom);
            for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
        end
        assign rdata = rpipe[RL-1];

        function automatic logic [11:0] ref_rd(input logic [14:0] a);
            return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
        endfunction

        function automatic string tg(input string s);
            return $sformatf("rl%0d %s", RL, s);
        endfunction

        // Entered and left just after a rising edge (start of cycle 0).
        task automatic xfer(input bit wr_dir, input bit illegal, input logic [14:0] a,
                            input logic [11:0] d, input int w, input int clr_at,
                            input bit clr_c1);
            bit aborted;
            int g_cyc, last_k;
            logic [11:0] exp_din;
            bit e_gnt, e_hold, e_we, e_re, e_err;
            aborted = !illegal && clr_at >= 1 && clr_at < w;
            if (illegal)     g_cyc = 1;
            else if (wr_dir) g_cyc = w + 2;
            else             g_cyc = w + 2 + RL;
            exp_din = (illegal || wr_dir || aborted) ? last_din : ref_rd(a);
            last_k  = aborted ? clr_at + 2 : g_cyc;
            for (int k = 0; k <= last_k; k++) begin
                req    = aborted ? (k <= clr_at) : 1'b1;
                rd     = illegal ? wr_dir : !wr_dir;
                wr     = wr_dir;
                addr   = a;
                dout   = d;
                brk_ok = (k < w) ? 1'b0 : (k == w) ? 1'b1 : 1'($urandom_range(0, 1));
                if (aborted)    clear = (k == clr_at);
                else if (k > w) clear = (clr_c1 && k == w + 1) ? 1'b1 : 1'($urandom_range(0, 1));
                else            clear = 1'b0;
                @(negedge clk);
                e_gnt  = !aborted && k == g_cyc;
                e_err  = illegal && k == g_cyc;
                e_hold = !aborted && !illegal && k > w && k <= g_cyc;
                e_we   = !aborted && !illegal && wr_dir && k == w + 1;
                e_re   = !aborted && !illegal && !wr_dir && k == w + 1;
                check_val(tg($sformatf("ctl gnt/hold/we/re/err k=%0d", k)),
                          32'({gnt, hold, we, re, err}),
                          32'({e_gnt, e_hold, e_we, e_re, e_err}));
                check_val(tg("din"), 32'(din), 32'(e_gnt ? exp_din : last_din));
                if (e_we) begin
                    check_val(tg("wr addr"), 32'(maddr), 32'(a));
                    check_val(tg("wr data"), 32'(wdata), 32'(d));
                end
                if (e_re) check_val(tg("rd addr"), 32'(maddr), 32'(a));
                @(posedge clk); #1;
            end
            if (!aborted && !illegal) begin
                if (wr_dir) ref_mem[int'(a)] = d;
                else        last_din = exp_din;
            end
        endtask

        task automatic idle_cycle();
            req    = 1'b0;
            clear  = 1'b0;
            brk_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val(tg("idle ctl"), 32'({gnt, hold, we, re, err}), 32'd0);
            check_val(tg("idle din"), 32'(din), 32'(last_din));
            @(posedge clk); #1;
        endtask

        task automatic reset_mid_read(input logic [14:0] a);
            req = 1'b1; rd = 1'b1; wr = 1'b0; addr = a; dout = '0;
            brk_ok = 1'b1; clear = 1'b0;
            @(posedge clk); #1;
            brk_ok = 1'b0;
            @(posedge clk); #1;
            check_val(tg("pre-reset hold"), 32'(hold), 32'd1);
            reset = 1'b1;
            #1;
            check_val(tg("async rst ctl"), 32'({gnt, hold, we, re, err}), 32'd0);
            check_val(tg("async rst din"), 32'(din), 32'd0);
            check_val(tg("async rst addr"), 32'(maddr), 32'd0);
            check_val(tg("async rst wdata"), 32'(wdata), 32'd0);
            last_din = '0;
            req = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_val(tg("post-rst ctl"), 32'({gnt, hold, we, re, err}), 32'd0);
                check_val(tg("post-rst din"), 32'(din), 32'd0);
                @(posedge clk); #1;
            end
        endtask

        initial begin
            bit dir, ill, cc1;
            int w, ca;
            reset = 1'b1; clear = 1'b0; req = 1'b0; rd = 1'b0; wr = 1'b0;
            brk_ok = 1'b0; addr = '0; dout = '0; last_din = '0;
            pool[0] = 15'o01234;
            pool[1] = 15'o70000;
            for (int i = 2; i < 8; i++) pool[i] = 15'($urandom);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_val(tg("reset ctl"), 32'({gnt, hold, we, re, err}), 32'd0);
            check_val(tg("reset din"), 32'(din), 32'd0);
            check_val(tg("reset addr"), 32'(maddr), 32'd0);
            reset = 1'b0;
            @(posedge clk); #1;

            xfer(1'b1, 1'b0, 15'o01234, 12'o7070, 0, -1, 1'b0);
            idle_cycle();
            xfer(1'b1, 1'b0, 15'o70000, 12'o4321, 0, -1, 1'b1);
            xfer(1'b0, 1'b0, 15'o70000, 12'o0000, 0, -1, 1'b0);
            check_val(tg("read 70000"), 32'(din), 32'(12'o4321));
            xfer(1'b1, 1'b0, pool[2], 12'($urandom), 10, -1, 1'b0);
            xfer(1'b0, 1'b0, pool[2], 12'o0000, 10, -1, 1'b0);
            xfer(1'b1, 1'b1, pool[3], 12'o1111, 0, -1, 1'b0);
            xfer(1'b0, 1'b1, pool[3], 12'o2222, 0, -1, 1'b0);
            xfer(1'b0, 1'b0, pool[3], 12'o0000, 6, 3, 1'b0);
            idle_cycle();
            reset_mid_read(15'o70000);
            xfer(1'b0, 1'b0, 15'o70000, 12'o0000, 0, -1, 1'b0);
            check_val(tg("read after reset"), 32'(din), 32'(12'o4321));

            for (int t = 0; t < 60; t++) begin
                dir = 1'($urandom_range(0, 1));
                ill = ($urandom_range(0, 7) == 0);
                cc1 = 1'($urandom_range(0, 1));
                w   = $urandom_range(0, 4);
                ca  = -1;
                if (!ill && w >= 2 && $urandom_range(0, 5) == 0) ca = $urandom_range(1, w - 1);
                xfer(dir, ill, pool[$urandom_range(0, 7)], 12'($urandom), w, ca, cc1);
                if ($urandom_range(0, 2) == 0) idle_cycle();
            end
            req = 1'b0;
            clear = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(lane[0].done && lane[1].done) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        check_val("lanes finished", 32'(lane[0].done & lane[1].done), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_break.md
# data_break

Memory-side responder for the disk DMA (data-break) handshake. Accepts word transfer requests from the RK8E/SD disk engine, waits for a CPU memory slot, runs exactly one memory read or write on the disk's behalf, and returns a one-cycle grant with read data. Sits between the disk controller's DMA port, the CPU's major-state sequencer and main memory.

## Interface

Parameters:
- READ_LATENCY, 1, cycles from `mem_re` to valid `mem_rdata` (1..4)
- ADDR_W, 15, memory address width (field + 12-bit address)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous IOCLR
- dmaREQ  in  1  disk requests a transfer; held until `dmaGNT`
- dmaRD  in  1  transfer is memory read (memory -> disk)
- dmaWR  in  1  transfer is memory write (disk -> memory)
- dmaADDR  in  ADDR_W  word address, stable while `dmaREQ`
- dmaDOUT  in  12  write data from disk, stable while `dmaREQ`
- dmaGNT  out  1  single-cycle transfer-complete pulse
- dmaDIN  out  12  read data to disk, valid in the `dmaGNT` cycle, held until the next read completes
- brk_ok  in  1  CPU is at a point where a break cycle may be inserted
- brk_hold  out  1  CPU must not access memory while high
- mem_addr  out  ADDR_W  memory address (valid only while `brk_hold`)
- mem_wdata  out  12  memory write data
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_rdata  in  12  memory read data
- proto_err  out  1  one-cycle pulse on an illegal request

## Operation

- States: IDLE, WAIT_SLOT, WRITE, READ_WAIT, GRANT.
- IDLE: `dmaREQ`=1 -> latch `dmaADDR`, `dmaDOUT`, direction. If `brk_ok`=1 the same cycle, go straight to WRITE or READ_WAIT; otherwise go to WAIT_SLOT.
- WAIT_SLOT: stay until `brk_ok`=1, then go to WRITE/READ_WAIT. No timeout.
- WRITE: `brk_hold`=1, `mem_we`=1 for one cycle with latched address/data -> GRANT.
- READ_WAIT: `mem_re`=1 in its first cycle only. Count READ_LATENCY cycles, capture `mem_rdata` into `dmaDIN` at the end of the last one -> GRANT.
- GRANT: `dmaGNT`=1, `brk_hold`=1 -> IDLE.
- Illegal request: `dmaRD`=`dmaWR` (both or neither) when sampled in IDLE.
  - No memory access and no `brk_hold`.
  - `proto_err` pulses in the next cycle, together with `dmaGNT`.
  - `dmaDIN` is unchanged.
- `dmaREQ` is ignored in GRANT. A request still high in the cycle after GRANT is a new transfer.
- `clear`:
  - In IDLE or WAIT_SLOT: return to IDLE, no grant, no memory access.
  - In WRITE, READ_WAIT or GRANT: ignored; the transfer completes and grants, so a memory cycle is never torn.
- `reset` (async): state IDLE. All outputs 0, including `dmaDIN`=0000 and `mem_addr`=0. The latched request is discarded.
- Addresses pass through unmodified; no field wrap or increment here (the requester owns the address).

## Timing

Cycle 0 is the cycle with `dmaREQ`=1 and `brk_ok`=1 in IDLE.

- Write:
  - `brk_hold` high in cycles 1–2.
  - `mem_we` in cycle 1.
  - `dmaGNT` in cycle 2.
- Read:
  - `mem_re` in cycle 1.
  - `mem_rdata` sampled at the end of cycle 1+READ_LATENCY.
  - `dmaGNT` and `dmaDIN` valid in cycle 2+READ_LATENCY.
  - `brk_hold` high from cycle 1 through the grant cycle.
- Each cycle spent in WAIT_SLOT adds one cycle to all of the above.
- Back-to-back requests: minimum spacing is grant cycle + 1 IDLE cycle, so write throughput is one word per 3 cycles when `brk_ok` is held high.
- `brk_ok` is sampled only in IDLE/WAIT_SLOT; dropping it mid-transfer has no effect.
- All outputs are registered; no combinational path from any input to any output.

## Test plan

- Write with `brk_ok`=1, `dmaADDR`=15'o01234, `dmaDOUT`=12'o7070 -> `mem_we` in cycle 1 with that address/data; `dmaGNT` in cycle 2; `brk_hold` in cycles 1–2 only.
- Read with READ_LATENCY=1, memory word 12'o4321 at 15'o70000 -> `mem_re` in cycle 1; `dmaGNT` in cycle 3 with `dmaDIN`=12'o4321. Repeat at READ_LATENCY=3 -> grant in cycle 5.
- Request with `brk_ok`=0 for 10 cycles -> no `brk_hold` or memory strobe during the wait. Raise `brk_ok` -> transfer starts the next cycle and `dmaGNT` follows per Timing.
- `dmaRD`=`dmaWR`=1 -> `proto_err` and `dmaGNT` in cycle 1; no `mem_we`/`mem_re`; `dmaDIN` unchanged.
- `clear` in WAIT_SLOT -> IDLE, no grant. `clear` in cycle 1 of a write -> write and grant still occur on schedule.
- Async `reset` asserted mid-READ_WAIT -> all outputs 0 immediately, no grant. Following request with `brk_ok`=1 behaves as in the read scenario.
